dsp_mac_slice: RTL

Parametrised, multi-channel successor to the single-channel DSP slice. Signed pre-add, multiply, accumulate datapath with a fixed 4-stage pipeline and a time-interleaved accumulator bank, so one slice serves `CHANNELS` independent dot-product streams. Framing is marked by per-sample FIRST/LAST tags. Optional saturation with sticky overflow. Sits between the sample front-end and the filter/correlator control logic.

---
 rtl/dsp_mac_slice_if.sv | 25 ++
 rtl/dsp_mac_slice.sv | 104 ++++++++++
 2 files changed

// File: rtl/dsp_mac_slice_if.sv
// dsp_mac_slice_if: sample-in / result-out bus of the multi-channel MAC slice.
interface dsp_mac_slice_if #(
  parameter int A_W   = 18,
  parameter int B_W   = 18,
  parameter int ACC_W = 48,
  parameter int CH_W  = 2
);
  logic             ce;
  logic             in_valid;
  logic [CH_W-1:0]  in_ch;
  logic             in_first;
  logic             in_last;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic [B_W-1:0]   d;
  logic [2:0]       opmode;
  logic             out_valid;
  logic [CH_W-1:0]  out_ch;
  logic [ACC_W-1:0] p;
  logic             ovf;
  modport master (output ce, in_valid, in_ch, in_first, in_last, a, b, d, opmode,
                  input  out_valid, out_ch, p, ovf);
  modport slave  (input  ce, in_valid, in_ch, in_first, in_last, a, b, d, opmode,
                  output out_valid, out_ch, p, ovf);
endinterface

// File: rtl/dsp_mac_slice.sv
// dsp_mac_slice: 4-stage signed pre-add/multiply/accumulate with a per-channel
// accumulator bank, FIRST/LAST framing and optional saturation.
module dsp_mac_slice #(
  parameter int A_W      = 18,
  parameter int B_W      = 18,
  parameter int ACC_W    = 48,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2,
  parameter int SATURATE = 1
) (
  input logic             clk,
  input logic             rst_n,
  dsp_mac_slice_if.slave  io_mac
);
  localparam int M_W = B_W + 1;
  localparam int P_W = A_W + B_W + 1;
  logic                    r1_valid, r1_first, r1_last;
  logic [CH_W-1:0]         r1_ch;
  logic [2:0]              r1_op;
  logic [A_W-1:0]          r1_a;
  logic [B_W-1:0]          r1_b, r1_d;
  logic                    r2_valid, r2_first, r2_last, r2_sub;
  logic [CH_W-1:0]         r2_ch;
  logic [A_W-1:0]          r2_a;
  logic [M_W-1:0]          r2_mb;
  logic                    r3_valid, r3_first, r3_last, r3_sub;
  logic [CH_W-1:0]         r3_ch;
  logic [P_W-1:0]          r3_prod;
  logic [ACC_W-1:0]        r_acc [CHANNELS];
  logic [CHANNELS-1:0]     r_ovf;
  logic                    r_out_valid, r_out_ovf;
  logic [CH_W-1:0]         r_out_ch;
  logic [ACC_W-1:0]        r_p;
  logic [M_W-1:0]          w_mb;
  logic [ACC_W:0]          w_base, w_prod, w_sum;
  logic [ACC_W-1:0]        w_wr;
  logic                    w_hit, w_of, w_ovf_new;
  always_comb begin
    w_mb      = !r1_op[0] ? {r1_b[B_W-1], r1_b}
              : r1_op[1]  ? {r1_d[B_W-1], r1_d} - {r1_b[B_W-1], r1_b}
              :             {r1_d[B_W-1], r1_d} + {r1_b[B_W-1], r1_b};
    w_hit     = r3_valid && int'(r3_ch) < CHANNELS;
    w_base    = r3_first ? '0 : {r_acc[r3_ch][ACC_W-1], r_acc[r3_ch]};
    w_prod    = {{(ACC_W-P_W+1){r3_prod[P_W-1]}}, r3_prod};
    w_sum     = r3_sub ? w_base - w_prod : w_base + w_prod;
    w_of      = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    // Clamp direction follows the true sign, which is the extra top bit of the sum.
    w_wr      = (w_of && SATURATE != 0)
              ? (w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
              : w_sum[ACC_W-1:0];
    w_ovf_new = (!r3_first && r_ovf[r3_ch]) || w_of;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r1_valid, r1_first, r1_last, r1_ch, r1_op, r1_a, r1_b, r1_d} <= '0;
      {r2_valid, r2_first, r2_last, r2_sub, r2_ch, r2_a, r2_mb} <= '0;
      {r3_valid, r3_first, r3_last, r3_sub, r3_ch, r3_prod} <= '0;
      for (int i = 0; i < CHANNELS; i++) r_acc[i] <= '0;
      r_ovf       <= '0;
      r_out_valid <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_ch    <= '0;
      r_p         <= '0;
    end else if (io_mac.ce) begin
      r1_valid    <= io_mac.in_valid;
      r1_first    <= io_mac.in_first;
      r1_last     <= io_mac.in_last;
      r1_ch       <= io_mac.in_ch;
      r1_op       <= io_mac.opmode;
      r1_a        <= io_mac.a;
      r1_b        <= io_mac.b;
      r1_d        <= io_mac.d;
      r2_valid    <= r1_valid;
      r2_first    <= r1_first;
      r2_last     <= r1_last;
      r2_sub      <= r1_op[2];
      r2_ch       <= r1_ch;
      r2_a        <= r1_a;
      r2_mb       <= w_mb;
      r3_valid    <= r2_valid;
      r3_first    <= r2_first;
      r3_last     <= r2_last;
      r3_sub      <= r2_sub;
      r3_ch       <= r2_ch;
      r3_prod     <= P_W'($signed(r2_a)) * P_W'($signed(r2_mb));
      if (w_hit) begin
        r_acc[r3_ch] <= w_wr;
        r_ovf[r3_ch] <= w_ovf_new;
      end
      r_out_valid <= w_hit && r3_last;
      if (w_hit && r3_last) begin
        r_p       <= w_wr;
        r_out_ch  <= r3_ch;
        r_out_ovf <= w_ovf_new;
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end
  assign io_mac.out_valid = r_out_valid;
  assign io_mac.out_ch    = r_out_ch;
  assign io_mac.p         = r_p;
  assign io_mac.ovf       = r_out_ovf;
endmodule
